// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/Mem pipeline stage register with valid/ready, flush and optional skid buffer
module ex_mem_pipe_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 101,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, pop;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept && (SKID != 0)) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over any load; data is left stale since ctrl alone gates side effects.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - bench for ex_mem_pipe_reg in skid and no-skid modes
module tb_ex_mem_pipe_reg;
  localparam int CW  = 9;
  localparam int DW  = 101;
  localparam int TOT = CW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
  logic [CW-1:0] s_out_ctrl, n_out_ctrl;
  logic [DW-1:0] s_out_data, n_out_data;
  logic [1:0]    s_occ, n_occ;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .occupancy(s_occ));

  ex_mem_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl),
    .out_data(n_out_data), .occupancy(n_occ));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each stage is a FIFO of {ctrl,data} with capacity 2 (skid) or 1 (no skid).
  logic [TOT-1:0] q1[$];
  logic [TOT-1:0] q0[$];
  logic [DW-1:0]  m1, m0;
  bit acc1, pop1, acc0, pop0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1.delete(); q0.delete();
      m1 = '0; m0 = '0;
    end else begin
      acc1 = in_valid && (q1.size() < 2);
      pop1 = (q1.size() > 0) && out_ready;
      acc0 = in_valid && ((q0.size() == 0) || out_ready);
      pop0 = (q0.size() > 0) && out_ready;
      if (flush) q1.delete();
      else begin
        if (pop1) void'(q1.pop_front());
        if (acc1) q1.push_back({in_ctrl, in_data});
        if (q1.size() > 0) m1 = q1[0][DW-1:0];
      end
      if (flush) q0.delete();
      else begin
        if (pop0) void'(q0.pop_front());
        if (acc0) q0.push_back({in_ctrl, in_data});
        if (q0.size() > 0) m0 = q0[0][DW-1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (started && rst) begin
      chk("s_out_valid", s_out_valid, q1.size() > 0);
      chk("s_occupancy", s_occ, q1.size());
      chk("s_in_ready", s_in_ready, q1.size() < 2);
      chk("s_out_ctrl", s_out_ctrl, (q1.size() > 0) ? q1[0][TOT-1:DW] : '0);
      chk("s_out_data", s_out_data, m1);
      chk("n_out_valid", n_out_valid, q0.size() > 0);
      chk("n_occupancy", n_occ, q0.size());
      chk("n_in_ready", n_in_ready, (q0.size() == 0) || out_ready);
      chk("n_out_ctrl", n_out_ctrl, (q0.size() > 0) ? q0[0][TOT-1:DW] : '0);
      chk("n_out_data", n_out_data, m0);
    end
  end

  task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic ordy, input logic fl);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk); #2;
  endtask

  initial begin
    #7 rst = 1'b0;
    #1;
    chk("rst_s_valid", s_out_valid, 0);
    chk("rst_s_occ", s_occ, 0);
    chk("rst_s_ready", s_in_ready, 1);
    chk("rst_s_ctrl", s_out_ctrl, 0);
    chk("rst_s_data", s_out_data, 0);
    chk("rst_n_ready", n_in_ready, 1);
    chk("rst_n_valid", n_out_valid, 0);
    #49 rst = 1'b1;
    started = 1;

    // streaming
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 9'h1FF, DW'(k), 1, 0);
      chk("stream_s_data", s_out_data, k);
      chk("stream_s_occ", s_occ, 1);
      chk("stream_s_ctrl", s_out_ctrl, 9'h1FF);
      chk("stream_n_data", n_out_data, k);
    end
    cyc(0, 0, 0, 1, 0);

    // backpressure
    cyc(1, 9'h0AB, 101'd10000, 0, 0);
    cyc(1, 9'h0CD, 101'd100000, 0, 0);
    chk("bp_s_occ", s_occ, 2);
    chk("bp_s_ready", s_in_ready, 0);
    chk("bp_s_head", s_out_data, 10000);
    chk("bp_n_occ", n_occ, 1);
    cyc(0, 0, 0, 1, 0);
    chk("bp_s_second", s_out_data, 100000);
    chk("bp_s_ready_back", s_in_ready, 1);
    cyc(0, 0, 0, 1, 0);
    chk("bp_s_drained", s_out_valid, 0);

    // flush in TWO with a beat offered
    cyc(1, 9'h001, 101'd5, 0, 0);
    cyc(1, 9'h002, 101'd6, 0, 0);
    cyc(1, 9'h003, 101'd7, 0, 1);
    chk("fl_s_occ", s_occ, 0);
    chk("fl_s_valid", s_out_valid, 0);
    chk("fl_s_ctrl", s_out_ctrl, 0);
    chk("fl_s_ready", s_in_ready, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("fl_s_never", s_out_valid, 0);

    // reset mid-operation
    cyc(1, 9'h004, 101'd8, 0, 0);
    cyc(1, 9'h005, 101'd9, 0, 0);
    in_valid = 0;
    rst = 1'b0;
    #1;
    chk("mrst_s_occ", s_occ, 0);
    chk("mrst_s_valid", s_out_valid, 0);
    chk("mrst_s_data", s_out_data, 0);
    chk("mrst_s_ready", s_in_ready, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    cyc(1, 9'h006, 101'd11, 1, 0);
    chk("mrst_resume_valid", s_out_valid, 1);
    chk("mrst_resume_data", s_out_data, 11);
    chk("mrst_resume_n_data", n_out_data, 11);

    // out_ready toggling with continuous input
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_ctrl = CW'(i + 1); in_data = DW'(20 + i);
      out_ready = (i % 2 == 0); flush = 0;
      #1;
      if (n_out_valid) chk("tog_n_track", n_in_ready, out_ready);
      chk("tog_n_occ_max", n_occ <= 2'd1, 1);
      @(posedge clk); #2;
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

    // mixed traffic with a flush
    for (int i = 0; i < 20; i++)
      cyc(1'(i % 4 != 3), CW'(i * 7 + 1), DW'(300 + i), 1'(i % 3 != 0), 1'(i == 13));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised pipeline-stage register, the successor to the fixed-width EX/Mem latch in the five-stage core. It carries a control bundle and a data bundle between adjacent stages with a valid/ready handshake, stall via backpressure, synchronous flush with bubble insertion, and an optional 2-entry skid buffer so `in_ready` is a registered signal. Default widths match the EX→Mem boundary: WB and Mem control, ALU result, Rt contents, PC+4 and Rd address.

## Interface

Parameters:
- `CTRL_W`, 9: control bundle width (LoadMux 2, MemToReg 2, RegWrite 1, MemWrite 1, MemRead 1, StoreMux 2).
- `DATA_W`, 101: data bundle width (ALUResult 32, RtContent 32, PCplus4 32, RdAddress 5).
- `SKID`, 1: 1 selects the 2-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: this stage accepts a beat this cycle.
- `in_ctrl` in CTRL_W: upstream control bundle.
- `in_data` in DATA_W: upstream data bundle.
- `flush` in 1: synchronous squash of all held entries.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts the head entry.
- `out_ctrl` out CTRL_W: head control, forced to 0 when `out_valid`=0.
- `out_data` out DATA_W: head data.
- `occupancy` out 2: entries held (0..2).

## Operation

- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Storage: main register (head) and skid register. The skid register exists only when SKID=1.
- FSM, SKID=1, with states EMPTY, ONE and TWO:
  - EMPTY: on accept, main←in and go to ONE.
  - ONE, accept and pop: main←in, stay in ONE.
  - ONE, accept without pop: skid←in, go to TWO.
  - ONE, pop without accept: go to EMPTY.
  - ONE, neither: hold.
  - TWO: `in_ready`=0. On pop, main←skid and go to ONE. Otherwise hold.
- `in_ready` (SKID=1) is a register equal to (next state ≠ TWO).
- SKID=0: only EMPTY and ONE exist.
  - `in_ready` = `!out_valid | out_ready`, combinational.
  - On accept, main←in.
- `out_valid` = (state ≠ EMPTY). `occupancy` encodes the state as 0, 1 or 2.
- Ordering is strict FIFO. Nothing is dropped or duplicated except on flush.
- Flush has the highest priority:
  - Next state is EMPTY and `in_ready` goes to 1.
  - Stored control fields are cleared to 0. Data registers hold their values.
  - A beat accepted in the flush cycle counts as handshaken upstream but is discarded.
  - A pop in the flush cycle completes normally downstream.
- Bubble gating: `out_ctrl` = main_ctrl AND `out_valid`. No write-enable ever leaks from an invalid slot.

## Timing

- Reset (`rst`=0, asynchronous) forces, regardless of `clk`:
  - state EMPTY, `out_valid`=0, `occupancy`=0;
  - `out_ctrl`=0, `out_data`=0, stored ctrl and data = 0;
  - `in_ready`=1 (SKID=1 register; combinationally 1 when SKID=0).
- Reset deassertion takes effect at the next rising edge. Reset mid-stream discards all entries.
- Latency: a beat accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: one beat per cycle sustained while `out_ready`=1, in both modes.
- SKID=1 backpressure: after `out_ready` falls, at most one extra beat is absorbed. `in_ready` falls on the edge that fills the skid. No input-to-`in_ready` combinational path exists.
- SKID=0: an `out_ready`→`in_ready` combinational path exists. No skid storage.
- Simultaneous accept and pop in TWO cannot occur, because `in_ready`=0 in TWO.

## Test plan

- **Reset:** hold `rst`=0 for 50 ns mid-clock → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1 immediately, before any edge.
- **Streaming:** `out_ready`=1; push ctrl=9'h1FF with data 1, 2, 3 on consecutive edges → out data 1, 2, 3 one cycle later each, `occupancy`=1 throughout.
- **Backpressure (SKID=1):** `out_ready`=0, push A=10000 and B=100000 → `occupancy`=2 and `in_ready`=0 after the second edge. Raise `out_ready` → A then B out in order, `in_ready` back to 1 after the first pop.
- **Flush:** flush in state TWO while `in_valid`=1 → next cycle `occupancy`=0, `out_valid`=0, `out_ctrl`=0, and the offered beat is never output.
- **Reset mid-operation:** drop `rst` in state TWO → outputs clear asynchronously. Accept resumes with `in_valid`=1 on the first edge after deassertion.
- **SKID=0 mode:** `out_ready` toggles 1,0,1,0 with continuous `in_valid` → `in_ready` tracks `out_ready` combinationally while full. `occupancy` never exceeds 1. All beats are delivered in order.
